// File: rtl/envelope_follower_if.sv
// envelope_follower_if: frame handshake in, per-channel envelope results out
interface envelope_follower_if #(parameter int N = 4, parameter int W = 32);
   localparam int CW = N > 1 ? $clog2(N) : 1;
   logic in_valid;
   logic in_ready;
   logic [N*W-1:0] in_data;
   logic out_valid;
   logic [CW-1:0] out_chan;
   logic [W-1:0] out_data;
   modport master(output in_valid, in_data, input in_ready, out_valid, out_chan, out_data);
   modport slave(input in_valid, in_data, output in_ready, out_valid, out_chan, out_data);
endinterface

// File: rtl/envelope_follower.sv
// envelope_follower: N-channel time-multiplexed attack/release envelope follower
module envelope_follower #(
   parameter int N = 4,
   parameter int W = 32,
   parameter int FRAC = 8
) (
   input  logic clk,
   input  logic rst_n,
   envelope_follower_if.slave bus,
   input  logic [3:0] k_attack,
   input  logic [3:0] k_release,
   input  logic mode,
   input  logic clr,
   output logic overrun
);
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam int SW = W + FRAC;
   localparam logic [SW:0] SMAX = {{(FRAC+2){1'b0}}, {(W-1){1'b1}}} << FRAC;
   localparam logic [W-1:0] XMIN = {1'b1, {(W-1){1'b0}}};
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [CW-1:0] chan, chan_nx;
   logic [N*W-1:0] frame;
   logic [3:0] ka, kr, k;
   logic md, last;
   logic [SW-1:0] s [N];
   logic [W-1:0] x, a;
   logic [SW:0] ext, cur, sum;
   logic [SW-1:0] nxt;
   assign bus.in_ready = state == IDLE;
   assign last = chan == CW'(N-1);
   // Saturating |x|: the most negative sample has no positive twin
   assign x = frame[chan*W +: W];
   assign a = x[W-1] ? (x == XMIN ? ~XMIN : -x) : x;
   assign ext = (SW+1)'(a) << FRAC;
   assign cur = {1'b0, s[chan]};
   assign k = (!md || ext > cur) ? ka : kr;
   assign sum = cur - (cur >> k) + (ext >> k);
   assign nxt = sum > SMAX ? SMAX[SW-1:0] : sum[SW-1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         chan <= '0;
      end else begin
         state <= state_nx;
         chan <= chan_nx;
      end
   always_comb begin
      state_nx = state;
      chan_nx = chan;
      if (clr) begin
         state_nx = IDLE;
         chan_nx = '0;
      end else if (state == IDLE) begin
         state_nx = bus.in_valid ? RUN : IDLE;
         chan_nx = '0;
      end else begin
         state_nx = last ? IDLE : RUN;
         chan_nx = last ? '0 : chan + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         frame <= '0;
         ka <= '0;
         kr <= '0;
         md <= 1'b0;
         overrun <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_chan <= '0;
         bus.out_data <= '0;
         for (int i = 0; i < N; i++) s[i] <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         if (clr) begin
            overrun <= 1'b0;
            for (int i = 0; i < N; i++) s[i] <= '0;
         end else begin
            if (bus.in_valid && state != IDLE) overrun <= 1'b1;
            if (bus.in_valid && state == IDLE) begin
               frame <= bus.in_data;
               ka <= k_attack;
               kr <= k_release;
               md <= mode;
            end
            if (state == RUN) begin
               s[chan] <= nxt;
               bus.out_valid <= 1'b1;
               bus.out_chan <= chan;
               bus.out_data <= nxt[SW-1:FRAC];
            end
         end
      end
endmodule

// File: tb/tb_envelope_follower.sv
// tb_envelope_follower: directed frame vectors plus overrun, clear and reset sequences
module tb_envelope_follower;
   localparam int N = 4, W = 16, FRAC = 8, NV = 10;
   logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, mode = 1'b0;
   logic [3:0] k_attack = '0, k_release = '0;
   logic overrun;
   int n_checks = 0, n_err = 0;
   typedef struct packed {
      logic pre_clr;
      logic md;
      logic [3:0] ka;
      logic [3:0] kr;
      logic [N-1:0][W-1:0] x;
      logic [N-1:0][W-1:0] y;
   } vec_t;
   vec_t v [NV];
   envelope_follower_if #(.N(N), .W(W)) bus();
   envelope_follower #(.N(N), .W(W), .FRAC(FRAC)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .k_attack(k_attack),
      .k_release(k_release), .mode(mode), .clr(clr), .overrun(overrun));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic vec_t mk(input bit pc, input bit md, input int ka, input int kr,
                               input int x0, x1, x2, x3, input int y0, y1, y2, y3);
      vec_t r;
      r.pre_clr = pc;
      r.md = md;
      r.ka = 4'(ka);
      r.kr = 4'(kr);
      r.x[0] = 16'(x0); r.x[1] = 16'(x1); r.x[2] = 16'(x2); r.x[3] = 16'(x3);
      r.y[0] = 16'(y0); r.y[1] = 16'(y1); r.y[2] = 16'(y2); r.y[3] = 16'(y3);
      return r;
   endfunction
   // Starts just after a negedge; disturbs the constants mid-frame to prove they were latched
   task automatic run_frame(input vec_t f, input int id);
      if (f.pre_clr) begin
         clr = 1'b1;
         @(negedge clk);
         clr = 1'b0;
      end
      k_attack = f.ka;
      k_release = f.kr;
      mode = f.md;
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = f.x[i];
      chk($sformatf("v%0d_ready_idle", id), int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      k_attack = ~f.ka;
      k_release = ~f.kr;
      mode = ~f.md;
      chk($sformatf("v%0d_ready_busy", id), int'(bus.in_ready), 0);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_valid%0d", id, i), int'(bus.out_valid), 1);
         chk($sformatf("v%0d_chan%0d", id, i), int'(bus.out_chan), i);
         chk($sformatf("v%0d_data%0d", id, i), int'(bus.out_data), int'(f.y[i]));
         chk($sformatf("v%0d_ready%0d", id, i), int'(bus.in_ready), i == N-1 ? 1 : 0);
      end
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      v[0] = mk(0, 0, 0, 0, 1000, -1000, 0, 0, 1000, 1000, 0, 0);
      v[1] = mk(0, 0, 3, 0, 1000, -1000, 800, -800, 1000, 1000, 100, 100);
      v[2] = mk(0, 0, 3, 0, 1000, -1000, 800, -800, 1000, 1000, 187, 187);
      v[3] = mk(0, 0, 3, 0, 1000, -1000, 800, -800, 1000, 1000, 264, 264);
      v[4] = mk(0, 0, 0, 0, -32768, 0, 5, -1, 32767, 0, 5, 1);
      v[5] = mk(0, 0, 1, 0, 32767, 100, 5, -1, 32767, 50, 5, 1);
      v[6] = mk(1, 1, 0, 2, 1000, 0, -2000, 7, 1000, 0, 2000, 7);
      v[7] = mk(0, 1, 0, 2, 0, 0, 0, 0, 750, 0, 1500, 5);
      v[8] = mk(0, 1, 0, 2, 0, 2000, 0, 0, 562, 2000, 1125, 3);
      v[9] = mk(0, 1, 0, 2, 2000, 0, 0, 0, 2000, 1500, 843, 2);
      repeat (2) @(negedge clk);
      chk("rst_ready", int'(bus.in_ready), 1);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_chan", int'(bus.out_chan), 0);
      chk("rst_data", int'(bus.out_data), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int j = 0; j < NV; j++) run_frame(v[j], j);
      // clr and a frame in the same cycle: the frame must be refused
      clr = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr_vs_valid_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      chk("clr_vs_valid_nout", int'(bus.out_valid), 0);
      // overrun: second frame offered at E2 of a running frame
      k_attack = 4'd0;
      mode = 1'b0;
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 16'd500;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ovr_set", int'(overrun), 1);
      chk("ovr_chan1", int'(bus.out_chan), 1);
      chk("ovr_data1", int'(bus.out_data), 500);
      repeat (5) @(negedge clk);
      chk("ovr_sticky", int'(overrun), 1);
      chk("ovr_dropped", int'(bus.out_valid), 0);
      chk("ovr_hold_chan", int'(bus.out_chan), 3);
      chk("ovr_hold_data", int'(bus.out_data), 500);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("ovr_cleared", int'(overrun), 0);
      run_frame(mk(0, 0, 2, 0, 100, -200, 300, 0, 25, 50, 75, 0), 20);
      // asynchronous reset between E2 and E3
      k_attack = 4'd0;
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 16'd4000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_valid", int'(bus.out_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(bus.out_valid), 0);
      chk("arst_ready", int'(bus.in_ready), 1);
      chk("arst_data", int'(bus.out_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(mk(0, 0, 2, 0, 100, -200, 300, 0, 25, 50, 75, 0), 21);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/envelope_follower.md
# envelope_follower

Multi-channel, time-weighted envelope follower for the audio path. It is the parametrised successor of the single-channel first-order absolute-value averager. It adds N channels time-multiplexed through one shared datapath, separate attack and release time constants, fractional guard bits, saturating absolute value and a valid/ready frame handshake. It sits after the filter bank and feeds level meters and the AGC. One frame (one sample per channel) is processed per DACLRCK-derived strobe.

## Interface
Parameters:
- `N`, default 4: channel count, 1..16.
- `W`, default 32: sample width, signed two's complement.
- `FRAC`, default 8: guard bits kept below the LSB in each channel's state.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: frame present on `in_data`.
- `in_ready`, out, 1: block idle and able to accept a frame.
- `in_data`, in, N*W: packed samples; channel i is `in_data[i*W +: W]`.
- `k_attack`, in, 4: shift constant used when |x| is above the envelope.
- `k_release`, in, 4: shift constant used when |x| is at or below the envelope.
- `mode`, in, 1: 0 = symmetric (`k_attack` used always); 1 = attack/release.
- `clr`, in, 1: synchronous clear of all channel states and `overrun`.
- `out_valid`, out, 1: one-cycle pulse per channel result.
- `out_chan`, out, clog2(N) (min 1): channel index of `out_data`.
- `out_data`, out, W: envelope, always ≥ 0.
- `overrun`, out, 1: sticky; a frame was offered while `in_ready` = 0.

## Operation
- State memory: N registers `s[i]`, each W+FRAC bits wide, unsigned-valued, held in a signed container.
- Absolute value: a = |x|. The most negative input maps to 2^(W-1)-1 (saturate). Extend a to A = a << FRAC.
- Direction select: k = `k_attack` when `mode` = 0, or when `mode` = 1 and A > s[i]. Otherwise k = `k_release`.
- Update: s' = s - (s >>> k) + (A >>> k). Compute at W+FRAC+1 bits and clamp to (2^(W-1)-1) << FRAC. With k = 0, s' = A.
- Output: `out_data` = s' >> FRAC (truncate).
- `k_attack`, `k_release` and `mode` are latched at frame acceptance. Changes mid-frame do not affect that frame.
- FSM states:
  - IDLE: `in_ready` = 1. On `in_valid`, latch `in_data` and the constants, set chan = 0, go to RUN.
  - RUN: process one channel per cycle. After channel N-1, go to IDLE.
- `clr` has priority over everything:
  - all s[i] = 0, `overrun` = 0, FSM → IDLE, no `out_valid` that cycle;
  - a frame offered in the same cycle as `clr` is not accepted.
- Overrun: `in_valid` = 1 while `in_ready` = 0 sets `overrun` (sticky). That frame is dropped and the upstream does not hold it.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_chan` = 0, `out_data` = 0, `overrun` = 0, all s[i] = 0, FSM = IDLE.
- Frame accepted at clock edge E0 (`in_valid` && `in_ready`). Channel i result is registered at edge E(i+1): `out_valid` = 1, `out_chan` = i.
- `in_ready` deasserts after E0 and reasserts after E(N). Throughput is one frame per N+1 cycles; the earliest next acceptance is at E(N+1).
- `out_data`/`out_chan` hold their last values while `out_valid` = 0.
- Reset asserted mid-RUN: immediate return to reset values; the remaining channels of the frame are lost.
- `in_valid` held high across a frame: accepted again at E(N+1). `overrun` is set by each cycle `in_valid` is high while `in_ready` is low (an upstream that holds valid must gate on ready).

## Test plan
- Settings N=4, W=16, FRAC=8, `mode`=0, `k_attack`=0, ch0=1000, ch1=-1000 → ch0 out 1000, ch1 out 1000, `out_chan` sequence 0,1,2,3 at E1..E4, `in_ready` high again after E4.
- `k_attack`=3, ch0=800 for consecutive frames from reset → outputs 100, 187, 264 (state 25600, 48000, 67600). Input -800 → identical outputs.
- ch0 = -32768, k=0 → out 32767. Then k=1 with input 32767 → no wrap, out stays 32767.
- `mode`=1, `k_attack`=0, `k_release`=2: frame ch0=1000, then ch0=0 → 1000, 750, 562. Then input 2000 → 2000 at once (attack path).
- Assert `in_valid` at E2 of a running frame → frame dropped, `overrun` = 1 and sticky. Then `clr` → `overrun` = 0, all outputs of the next frame computed from zero state.
- Drop `rst_n` between E2 and E3 → `out_valid` = 0 and `in_ready` = 1 asynchronously. The next frame starts from zero state.
